onchip_mem_arbiter: RTL and testbench

- Two-master arbiter sharing the single-port, 2048x32 on-chip memory between the instruction-fetch master (m0) and the data master (m1) of the core.
- Each side is an Avalon-MM slave port with waitrequest and readdatavalid.
- Issues at most one memory access per cycle, tracks the 1-cycle read latency and routes read data back to the issuing master.
- Sits between the core bus ports and the memory's s1 interface.

---
 rtl/onchip_mem_arbiter_if.sv | 60 ++++++
 rtl/onchip_mem_arbiter.sv | 102 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_arbiter_if
// Description : Bus bundle between the two core masters, the arbiter and the
//               single-port on-chip memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // instruction-fetch master
  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic              m0_waitrequest;

  // data master
  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic              m1_waitrequest;

  // memory side
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  m0_address, m0_read,
    output m0_readdata, m0_readdatavalid, m0_waitrequest,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_readdata, m1_readdatavalid, m1_waitrequest,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_read,
    input  m0_readdata, m0_readdatavalid, m0_waitrequest,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_readdata, m1_readdatavalid, m1_waitrequest,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_arbiter
// Description : Two-master arbiter (fetch m0, data m1) for a single-port
//               on-chip memory with 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset,
  onchip_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic grant;
  logic rd_issue;
  logic sel;

  logic last_gnt_q, last_gnt_d;
  logic sel_q, sel_d;
  logic rd_vld_q, rd_vld_d;
  logic rd_tag_q, rd_tag_d;

  // Grants are purely request/state driven; mem_readdata never feeds them.
  always_comb begin
    req0 = bus.m0_read;
    req1 = bus.m1_read | bus.m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (FIXED_PRIO != 0) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = last_gnt_q;
          gnt1 = ~last_gnt_q;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    grant    = gnt0 | gnt1;
    // A simultaneous read+write from m1 is treated as a write only.
    rd_issue = gnt0 | (gnt1 & bus.m1_read & ~bus.m1_write);
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    rd_tag_d   = rd_tag_q;
    rd_vld_d   = rd_issue;
    if (grant) begin
      last_gnt_d = gnt1;
      sel_d      = gnt1;
    end
    if (rd_issue) begin
      rd_tag_d = gnt1;
    end
    sel = grant ? gnt1 : sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_tag_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      rd_vld_q   <= rd_vld_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  assign bus.m0_waitrequest = req0 & ~gnt0;
  assign bus.m1_waitrequest = req1 & ~gnt1;

  // With no grant the buses follow the last granted master so q-side glitching is avoided.
  assign bus.mem_address    = sel ? bus.m1_address    : bus.m0_address;
  assign bus.mem_byteenable = sel ? bus.m1_byteenable : {BE_W{1'b1}};
  assign bus.mem_writedata  = sel ? bus.m1_writedata  : {DATA_W{1'b0}};
  assign bus.mem_chipselect = grant;
  assign bus.mem_write      = gnt1 & bus.m1_write;
  assign bus.mem_clken      = grant | (rd_vld_q & ~reset);

  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;
  assign bus.m0_readdatavalid = rd_vld_q & ~rd_tag_q & ~reset;
  assign bus.m1_readdatavalid = rd_vld_q &  rd_tag_q & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_arbiter
// Description : Self-checking bench for onchip_mem_arbiter (round-robin and
//               fixed-priority instances) with behavioural memories.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        rst;
    logic        r0;
    logic [10:0] a0;
    logic        r1;
    logic        w1;
    logic [10:0] a1;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        g0;
    logic        g1;
  } vec_t;

  typedef struct packed {
    logic        tag;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) dut_rr (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1)) dut_fp (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  function automatic logic [31:0] pat(input logic [10:0] a);
    return (a == 11'd16) ? 32'h0 : {16'hA5A5, 5'b0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port memories: q updates only on enabled reads.
  logic [31:0] st_a [0:2047];
  bit          wr_a [0:2047];
  logic [31:0] q_a = 32'h0;
  logic [31:0] st_b [0:2047];
  bit          wr_b [0:2047];
  logic [31:0] q_b = 32'h0;

  assign bus_a.mem_readdata = q_a;
  assign bus_b.mem_readdata = q_b;

  always @(posedge clk) begin
    if (bus_a.mem_clken && bus_a.mem_chipselect) begin
      if (bus_a.mem_write) begin
        st_a[bus_a.mem_address] <= merge(wr_a[bus_a.mem_address] ? st_a[bus_a.mem_address]
                                         : pat(bus_a.mem_address),
                                         bus_a.mem_writedata, bus_a.mem_byteenable);
        wr_a[bus_a.mem_address] <= 1'b1;
      end else begin
        q_a <= wr_a[bus_a.mem_address] ? st_a[bus_a.mem_address] : pat(bus_a.mem_address);
      end
    end
    if (bus_b.mem_clken && bus_b.mem_chipselect) begin
      if (bus_b.mem_write) begin
        st_b[bus_b.mem_address] <= merge(wr_b[bus_b.mem_address] ? st_b[bus_b.mem_address]
                                         : pat(bus_b.mem_address),
                                         bus_b.mem_writedata, bus_b.mem_byteenable);
        wr_b[bus_b.mem_address] <= 1'b1;
      end else begin
        q_b <= wr_b[bus_b.mem_address] ? st_b[bus_b.mem_address] : pat(bus_b.mem_address);
      end
    end
  end

  logic [31:0] ref_mem [0:2047];
  sb_t         exp_q[$];
  logic [31:0] last_rd = 32'h0;
  logic        exp_sel = 1'b0;

  task automatic chk(input int i, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL v%0d %s: got %h want %h", i, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic r0, input logic [10:0] a0,
                              input logic r1, input logic w1, input logic [10:0] a1,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic g0, input logic g1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.be = be; v.wd = wd; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic drive_a(input vec_t v);
    rst_a               = v.rst;
    bus_a.m0_read       = v.r0;
    bus_a.m0_address    = v.a0;
    bus_a.m1_read       = v.r1;
    bus_a.m1_write      = v.w1;
    bus_a.m1_address    = v.a1;
    bus_a.m1_byteenable = v.be;
    bus_a.m1_writedata  = v.wd;
  endtask

  task automatic drive_b(input logic rst, input logic r0, input logic [10:0] a0,
                         input logic r1, input logic [10:0] a1);
    rst_b               = rst;
    bus_b.m0_read       = r0;
    bus_b.m0_address    = a0;
    bus_b.m1_read       = r1;
    bus_b.m1_write      = 1'b0;
    bus_b.m1_address    = a1;
    bus_b.m1_byteenable = 4'hF;
    bus_b.m1_writedata  = 32'h0;
  endtask

  task automatic check_a(input int i, input vec_t v);
    logic pend;
    sb_t  e;
    pend = (exp_q.size() != 0);
    // Returns first: what was issued last cycle must come back now.
    if (v.rst) begin
      chk(i, "rdv0_rst", bus_a.m0_readdatavalid, 0);
      chk(i, "rdv1_rst", bus_a.m1_readdatavalid, 0);
      if (pend) begin
        last_rd = exp_q[0].data;
        exp_q.delete();
      end
    end else if (pend) begin
      e = exp_q.pop_front();
      chk(i, "rdv0", bus_a.m0_readdatavalid, {31'b0, ~e.tag});
      chk(i, "rdv1", bus_a.m1_readdatavalid, {31'b0, e.tag});
      chk(i, "rdata0", bus_a.m0_readdata, e.data);
      chk(i, "rdata1", bus_a.m1_readdata, e.data);
      last_rd = e.data;
    end else begin
      chk(i, "rdv0_idle", bus_a.m0_readdatavalid, 0);
      chk(i, "rdv1_idle", bus_a.m1_readdatavalid, 0);
      chk(i, "q_hold", bus_a.mem_readdata, last_rd);
    end
    chk(i, "wait0", bus_a.m0_waitrequest, {31'b0, v.r0 & ~v.g0});
    chk(i, "wait1", bus_a.m1_waitrequest, {31'b0, (v.r1 | v.w1) & ~v.g1});
    chk(i, "cs", bus_a.mem_chipselect, {31'b0, v.g0 | v.g1});
    chk(i, "wr", bus_a.mem_write, {31'b0, v.g1 & v.w1});
    chk(i, "clken", bus_a.mem_clken, {31'b0, v.g0 | v.g1 | (pend & ~v.rst)});
    if (v.g0) begin
      chk(i, "addr_g0", bus_a.mem_address, v.a0);
      chk(i, "be_g0", bus_a.mem_byteenable, 4'hF);
      chk(i, "wd_g0", bus_a.mem_writedata, 0);
      exp_q.push_back({1'b0, ref_mem[v.a0]});
    end else if (v.g1) begin
      chk(i, "addr_g1", bus_a.mem_address, v.a1);
      chk(i, "be_g1", bus_a.mem_byteenable, v.be);
      if (v.w1) begin
        chk(i, "wd_g1", bus_a.mem_writedata, v.wd);
        ref_mem[v.a1] = merge(ref_mem[v.a1], v.wd, v.be);
      end else begin
        exp_q.push_back({1'b1, ref_mem[v.a1]});
      end
    end else if (!v.rst) begin
      chk(i, "addr_hold", bus_a.mem_address, exp_sel ? v.a1 : v.a0);
    end
    if (v.rst) exp_sel = 1'b0;
    else if (v.g0 || v.g1) exp_sel = v.g1;
  endtask

  vec_t vecs[$];
  vec_t idle_v;

  initial begin
    for (int k = 0; k < 2048; k++) ref_mem[k] = pat(k[10:0]);
    idle_v = mk(0, 0, 11'd0, 0, 0, 11'd0, 4'hF, 32'h0, 0, 0);
    drive_a(mk(1, 1, 11'd1, 1, 0, 11'd2, 4'hF, 32'h0, 0, 0));
    drive_b(1, 0, 11'd0, 0, 11'd0);

    //                 rst r0 a0      r1 w1 a1      be    wd            g0 g1
    vecs.push_back(mk(1, 1, 11'd1,  1, 0, 11'd2,  4'hF, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 11'd1,  1, 0, 11'd2,  4'hF, 32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 11'd1,  1, 0, 11'd2,  4'hF, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 11'd3,  1, 0, 11'd2,  4'hF, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 11'd3,  1, 0, 11'd4,  4'hF, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 11'd5,  1, 0, 11'd4,  4'hF, 32'h0,        0, 1));
    vecs.push_back(idle_v);
    vecs.push_back(mk(0, 0, 11'd0,  0, 1, 11'd16, 4'h3, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, 1, 11'd16, 0, 0, 11'd0,  4'hF, 32'h0,        1, 0));
    vecs.push_back(idle_v);
    vecs.push_back(mk(0, 0, 11'd0,  1, 1, 11'd32, 4'hF, 32'h12345678, 0, 1));
    vecs.push_back(idle_v);
    vecs.push_back(mk(0, 1, 11'd32, 0, 1, 11'd33, 4'hF, 32'hCAFEF00D, 1, 0));
    vecs.push_back(mk(0, 0, 11'd0,  0, 1, 11'd33, 4'hF, 32'hCAFEF00D, 0, 1));
    vecs.push_back(mk(0, 1, 11'd33, 0, 0, 11'd0,  4'hF, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 11'd0,  1, 0, 11'd33, 4'hF, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 11'd0,  0, 0, 11'd0,  4'hF, 32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 11'd32, 0, 0, 11'd0,  4'hF, 32'h0,        1, 0));
    for (int k = 0; k < 6; k++) vecs.push_back(idle_v);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive_a(vecs[i]);
      @(negedge clk);
      check_a(i, vecs[i]);
    end
    chk(100, "sb_empty", exp_q.size(), 0);

    // Explicit read-back of the partial write to 0x10.
    @(posedge clk); #1;
    drive_a(mk(0, 1, 11'd16, 0, 0, 11'd0, 4'hF, 32'h0, 0, 0));
    @(negedge clk);
    chk(101, "rb_wait0", bus_a.m0_waitrequest, 0);
    chk(101, "rb_cs", bus_a.mem_chipselect, 1);
    @(posedge clk); #1;
    drive_a(idle_v);
    @(negedge clk);
    chk(102, "rb_rdv0", bus_a.m0_readdatavalid, 1);
    chk(102, "rb_rdv1", bus_a.m1_readdatavalid, 0);
    chk(102, "rb_data", bus_a.m0_readdata, 32'h0000BEEF);

    // Fixed priority: m1 streams reads, m0 waits until m1 drops.
    @(posedge clk); #1;
    drive_b(1, 1, 11'd7, 1, 11'd8);
    @(negedge clk);
    chk(200, "fp_rst_wait0", bus_b.m0_waitrequest, 1);
    chk(200, "fp_rst_wait1", bus_b.m1_waitrequest, 1);
    chk(200, "fp_rst_cs", bus_b.mem_chipselect, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive_b(0, 1, 11'd7, 1, 11'(8 + k));
      @(negedge clk);
      chk(201 + k, "fp_wait0", bus_b.m0_waitrequest, 1);
      chk(201 + k, "fp_wait1", bus_b.m1_waitrequest, 0);
      chk(201 + k, "fp_addr", bus_b.mem_address, 11'(8 + k));
      if (k > 0) begin
        chk(201 + k, "fp_rdv1", bus_b.m1_readdatavalid, 1);
        chk(201 + k, "fp_data1", bus_b.m1_readdata, pat(11'(7 + k)));
      end
    end
    @(posedge clk); #1;
    drive_b(0, 1, 11'd7, 0, 11'd0);
    @(negedge clk);
    chk(204, "fp_m0_wait0", bus_b.m0_waitrequest, 0);
    chk(204, "fp_m0_cs", bus_b.mem_chipselect, 1);
    chk(204, "fp_m0_addr", bus_b.mem_address, 11'd7);
    chk(204, "fp_m0_rdv1", bus_b.m1_readdatavalid, 1);
    chk(204, "fp_m0_data1", bus_b.m1_readdata, pat(11'd10));
    @(posedge clk); #1;
    drive_b(0, 0, 11'd0, 0, 11'd0);
    @(negedge clk);
    chk(205, "fp_rdv0", bus_b.m0_readdatavalid, 1);
    chk(205, "fp_rdv1_off", bus_b.m1_readdatavalid, 0);
    chk(205, "fp_data0", bus_b.m0_readdata, pat(11'd7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
